// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 24-hour BCD time-of-day counter.
// The divided tick from the upstream stage is sampled as a level on clk and
// edge-detected. A prescaler turns TICKS_PER_SEC rises into one second.
// A parallel load is range-checked, and there are per-field increment buttons.
// Parameter constraints: TICKS_PER_SEC in 2..1024, 2**CNT_W >= TICKS_PER_SEC.
module clock_time_keeper #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int CNT_W         = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam logic [CNT_W-1:0] MS_LAST = CNT_W'(TICKS_PER_SEC - 1);

    // Increment a packed BCD field and wrap to 00 after 'last'.
    // Bit 8 of the result is the wrap (carry-out) flag.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // A BCD field is legal when both digits are decimal and it does not exceed 'max'.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    logic             tick_d;
    logic             pend;
    logic [CNT_W-1:0] ms_cnt;

    logic       rise;
    logic       step_req;
    logic       sec_wrap;
    logic       load_ok;
    logic [8:0] ss_n;
    logic [8:0] mm_n;
    logic [8:0] hh_n;

    // Edge detect, pending-rise merge and next-value computation for each field.
    always_comb begin
        rise     = tick_in & ~tick_d;
        step_req = rise | pend;
        sec_wrap = (ms_cnt == MS_LAST);
        load_ok  = bcd_ok(load_ss, 8'h59) && bcd_ok(load_mm, 8'h59) && bcd_ok(load_hh, 8'h23);
        ss_n     = bcd_inc(seconds, 8'h59);
        mm_n     = bcd_inc(minutes, 8'h59);
        hh_n     = bcd_inc(hours,   8'h23);
    end

    // Priority per cycle: load, then increments (a rise is deferred into pend),
    // then the prescaler step driven by a fresh or pending rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d    <= 1'b1;
            pend      <= 1'b0;
            ms_cnt    <= '0;
            hours     <= 8'h00;
            minutes   <= 8'h00;
            seconds   <= 8'h00;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            tick_d    <= tick_in;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                // Any rise in this cycle is dropped, whether the load is accepted or not.
                if (load_ok) begin
                    hours   <= load_hh;
                    minutes <= load_mm;
                    seconds <= load_ss;
                    ms_cnt  <= '0;
                    pend    <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (inc_min || inc_hour) begin
                if (inc_min)
                    minutes <= mm_n[7:0];
                if (inc_hour)
                    hours <= hh_n[7:0];
                // Rises are at least two cycles apart, so one deep is enough.
                pend <= step_req;
            end else begin
                pend <= 1'b0;
                if (step_req) begin
                    if (sec_wrap) begin
                        ms_cnt    <= '0;
                        seconds   <= ss_n[7:0];
                        sec_pulse <= 1'b1;
                        if (ss_n[8]) begin
                            minutes <= mm_n[7:0];
                            if (mm_n[8]) begin
                                hours     <= hh_n[7:0];
                                day_pulse <= hh_n[8];
                            end
                        end
                    end else begin
                        ms_cnt <= ms_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Time-of-day core for the digital clock. Sits directly downstream of the divide-by-1000 stage: consumes its 50%-duty slow clock (one rising edge per 1000 `clk` cycles) as a sampled level, prescales to 1 Hz, and maintains a 24-hour BCD hh:mm:ss count. Also supports a validated parallel load and per-field increment buttons. Everything runs on `clk`; `tick_in` is never used as a clock.

## Interface
- `TICKS_PER_SEC`, 1000: `tick_in` rising edges per second. Legal range is 2..1024.
- `CNT_W`, 10: prescaler width. Must satisfy 2^CNT_W >= TICKS_PER_SEC.
- `clk`  in  1  system clock. Also clocks the upstream divider.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `tick_in`  in  1  divided clock from upstream, registered in the `clk` domain. Only its rising edge is meaningful.
- `load`  in  1  one-cycle pulse; load `load_hh`/`load_mm`/`load_ss`.
- `load_hh`, `load_mm`, `load_ss`  in  8 each  packed BCD (tens in [7:4], units in [3:0]).
- `inc_min`  in  1  one-cycle pulse; minutes +1 mod 60, no carry.
- `inc_hour`  in  1  one-cycle pulse; hours +1 mod 24.
- `hours`, `minutes`, `seconds`  out  8 each  packed BCD, registered.
- `sec_pulse`  out  1  one-cycle pulse when seconds advance from the prescaler.
- `day_pulse`  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
- `load_err`  out  1  one-cycle pulse when a `load` is rejected.

## Operation
- **Edge detect:** register `tick_d` <= `tick_in`; `rise` = `tick_in` & ~`tick_d`. `tick_d` resets to 1, so a high `tick_in` at reset release does not produce an edge.
- **Prescaler** `ms_cnt` (CNT_W bits), on each applied `rise`:
  - if `ms_cnt` == TICKS_PER_SEC-1: `ms_cnt` <= 0 and seconds advance;
  - otherwise `ms_cnt` +1.
- **Time advance (BCD):**
  - Units digit 9 -> 0 with carry into tens.
  - seconds 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours; hours 23 -> 00 pulses `day_pulse`.
  - Ripple is completed within one cycle.
- **Priority in a cycle, highest first:** `load` > `inc_min`/`inc_hour` > `rise`.
- **`load` handling:**
  - Valid if every digit <= 9, `load_ss` <= 0x59, `load_mm` <= 0x59, `load_hh` <= 0x23. Then all three fields are replaced, `ms_cnt` <= 0, and the pending flag is cleared.
  - If invalid: nothing changes, `load_err` = 1 for one cycle, and a `rise` in that cycle is discarded.
  - A valid load also discards a `rise` in the same cycle.
- **Increments:**
  - `inc_min` and `inc_hour` may be asserted together; both apply. Seconds and `ms_cnt` are untouched.
  - A `rise` arriving in the same cycle sets `pend`; it is applied in the next cycle as if `rise` were asserted then.
  - `pend` is one deep. Rises are at least 2 cycles apart for a 50% duty input, so no overflow is possible.
- `sec_pulse` and `day_pulse` come only from prescaler-driven advances, never from load or inc.
- **Reset values:** `hours` = `minutes` = `seconds` = 0x00; `ms_cnt` = 0; `pend` = 0; `tick_d` = 1; `sec_pulse` = `day_pulse` = `load_err` = 0.

## Timing
- `tick_in` rises after edge k. The rise is seen during cycle k..k+1.
- At edge k+1, `ms_cnt` updates. On a second boundary, `seconds` (and any carried fields) update and `sec_pulse` is high from k+1 to k+2.
- Deferred rise: all effects shift one cycle later.
- `load` sampled at edge j: the new fields, or `load_err`, are visible after edge j.
- Increments follow the same rule: visible after the sampling edge.
- Asynchronous reset mid-second returns all state to reset values immediately. Counting restarts from 00:00:00 with `ms_cnt` = 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset and prescale:** reset, TICKS_PER_SEC=4, drive `tick_in` at period 8 `clk` -> `seconds` = 0x01 after the 4th rise; `sec_pulse` is exactly one cycle wide, once per 4 rises.
- **Day rollover:** load 23:59:59, then 4 rises -> 00:00:00 with `day_pulse` and `sec_pulse` in the same single cycle. Also 09:59:59 -> 10:00:00 with no `day_pulse`.
- **Invalid load:** `load` with `load_mm` = 0x60 (and separately `load_ss` = 0x1A, `load_hh` = 0x24) -> `load_err` = 1 for one cycle; time unchanged.
- **Increment wrap:** `inc_min` at 12:59:30 -> 12:00:30. `inc_hour` at 23:15:00 -> 00:15:00 with no `day_pulse`. Both together at 23:59:10 -> 00:00:10.
- **Increment vs rise:** `inc_min` coincident with the 4th rise at 10:20:59 -> 10:21:59 after the inc edge, then 10:22:00 with `sec_pulse` one cycle later.
- **Reset mid-count:** assert `rst_n` low at 05:06:07 with `ms_cnt` = 2 -> all outputs 0 asynchronously. Releasing reset while `tick_in` = 1 produces no spurious edge.
